// File: rtl/bmat_bank_buf_if.sv
// Weight-stream / MAC-array interface of the banked weight-tile buffer.
// The master drives beats and swap pulses; the slave (buffer) returns the tile.
interface bmat_bank_buf_if #(
  parameter int unsigned SZI       = 8,
  parameter int unsigned SZJ       = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NBANKS    = 2,
  parameter int unsigned YGEN_MODE = 0
);
  localparam int unsigned QW = WIDTH + YGEN_MODE;
  localparam int unsigned FW = $clog2(NBANKS + 1);

  logic                     d_valid;
  logic                     d_ready;
  logic [SZJ*WIDTH-1:0]     d;
  logic                     d_last;
  logic                     swap;
  logic [SZI*SZJ*QW-1:0]    q;
  logic                     q_valid;
  logic [FW-1:0]            fill_count;
  logic                     err;

  modport master (
    output d_valid, d, d_last, swap,
    input  d_ready, q, q_valid, fill_count, err
  );

  modport slave (
    input  d_valid, d, d_last, swap,
    output d_ready, q, q_valid, fill_count, err
  );
endinterface

// File: rtl/bmat_bank_buf.sv
// Ring of NBANKS weight tiles. Rows are loaded through a valid/ready stream,
// the oldest complete tile is presented on q, and a swap pulse retires it.
// With YGEN_MODE set, each stored row is the difference to the previous row.
module bmat_bank_buf #(
  parameter int unsigned SZI       = 8,
  parameter int unsigned SZJ       = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NBANKS    = 2,
  parameter int unsigned YGEN_MODE = 0,
  parameter int unsigned SIGNED    = 1
) (
  input logic             clk,
  input logic             resetn,
  bmat_bank_buf_if.slave  bus
);
  localparam int unsigned QW = WIDTH + YGEN_MODE;
  localparam int unsigned BW = $clog2(NBANKS);
  localparam int unsigned RW = (SZI > 1) ? $clog2(SZI) : 1;
  localparam int unsigned FW = $clog2(NBANKS + 1);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkActive} bank_st_e;

  bank_st_e              r_st [NBANKS];
  bank_st_e              w_st_d [NBANKS];
  logic [BW-1:0]         r_wp, w_wp_d, w_wp_nxt;
  logic [BW-1:0]         r_rp, w_rp_d, w_rp_nxt;
  logic [RW-1:0]         r_rowcnt, w_rowcnt_d;
  logic [SZJ*WIDTH-1:0]  r_prev, w_prev_d;
  logic                  r_d_ready, w_d_ready_d;
  logic                  r_err, w_err_d;
  logic [FW-1:0]         r_fill, w_fill_d;
  logic [SZJ*QW-1:0]     r_mem [NBANKS][SZI];
  logic [SZJ*QW-1:0]     w_row;
  logic [SZI*SZJ*QW-1:0] w_q;
  logic                  w_accept, w_close, w_q_valid;

  assign w_accept  = bus.d_valid && r_d_ready;
  assign w_close   = w_accept && (r_rowcnt == RW'(SZI - 1));
  // The ACTIVE bank, when present, is always bank[rp].
  assign w_q_valid = (r_st[r_rp] == BkActive);
  assign w_wp_nxt  = (r_wp == BW'(NBANKS - 1)) ? '0 : r_wp + 1'b1;
  assign w_rp_nxt  = (r_rp == BW'(NBANKS - 1)) ? '0 : r_rp + 1'b1;

  for (genvar gj = 0; gj < SZJ; gj++) begin : g_col
    logic [WIDTH-1:0] w_cur, w_prv;
    assign w_cur = bus.d[gj*WIDTH +: WIDTH];
    assign w_prv = r_prev[gj*WIDTH +: WIDTH];

    if (YGEN_MODE != 0) begin : g_ygen
      logic [WIDTH:0] w_cur_x, w_prv_x;
      assign w_cur_x = {(SIGNED != 0) & w_cur[WIDTH-1], w_cur};
      assign w_prv_x = {(SIGNED != 0) & w_prv[WIDTH-1], w_prv};
      // One extra bit makes the difference exact.
      assign w_row[gj*QW +: QW] = w_cur_x - w_prv_x;
    end else begin : g_raw
      assign w_row[gj*QW +: QW] = w_cur;
    end

    for (genvar gi = 0; gi < SZI; gi++) begin : g_row
      assign w_q[(gj*SZI+gi)*QW +: QW] = w_q_valid ? r_mem[r_rp][gi][gj*QW +: QW] : '0;
    end
  end

  // Next-state for bank states, pointers, row counter, error and flow control.
  always_comb begin
    for (int b = 0; b < NBANKS; b++) begin
      w_st_d[b] = r_st[b];
    end
    w_wp_d      = r_wp;
    w_rp_d      = r_rp;
    w_rowcnt_d  = r_rowcnt;
    w_prev_d    = r_prev;
    w_err_d     = r_err;
    w_fill_d    = '0;
    w_d_ready_d = 1'b0;

    if (w_accept) begin
      // d_last must coincide exactly with the final row.
      w_err_d = w_err_d | (bus.d_last ^ w_close);
      if (w_close) begin
        w_st_d[r_wp] = BkFull;
        w_rowcnt_d   = '0;
        w_prev_d     = '0;
        w_wp_d       = w_wp_nxt;
      end else begin
        w_st_d[r_wp] = BkFilling;
        w_rowcnt_d   = r_rowcnt + 1'b1;
        w_prev_d     = bus.d;
      end
    end

    if (bus.swap) begin
      if (w_q_valid) begin
        w_st_d[r_rp] = BkEmpty;
        w_rp_d       = w_rp_nxt;
        // Zero-bubble handover only for a tile that was already FULL.
        if (r_st[w_rp_nxt] == BkFull) begin
          w_st_d[w_rp_nxt] = BkActive;
        end
      end else begin
        w_err_d = 1'b1;
      end
    end

    if (!w_q_valid && (r_st[r_rp] == BkFull)) begin
      w_st_d[r_rp] = BkActive;
    end

    for (int b = 0; b < NBANKS; b++) begin
      if ((w_st_d[b] == BkFull) || (w_st_d[b] == BkActive)) begin
        w_fill_d = w_fill_d + FW'(1);
      end
    end
    w_d_ready_d = (w_st_d[w_wp_d] == BkEmpty) || (w_st_d[w_wp_d] == BkFilling);
  end

  // Control state registers; reset discards any partially loaded tile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int b = 0; b < NBANKS; b++) begin
        r_st[b] <= BkEmpty;
      end
      r_wp      <= '0;
      r_rp      <= '0;
      r_rowcnt  <= '0;
      r_prev    <= '0;
      r_err     <= 1'b0;
      r_fill    <= '0;
      r_d_ready <= 1'b0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        r_st[b] <= w_st_d[b];
      end
      r_wp      <= w_wp_d;
      r_rp      <= w_rp_d;
      r_rowcnt  <= w_rowcnt_d;
      r_prev    <= w_prev_d;
      r_err     <= w_err_d;
      r_fill    <= w_fill_d;
      r_d_ready <= w_d_ready_d;
    end
  end

  // Tile storage; contents are only observed through a valid bank state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wp][r_rowcnt] <= w_row;
    end
  end

  assign bus.d_ready    = r_d_ready;
  assign bus.q          = w_q;
  assign bus.q_valid    = w_q_valid;
  assign bus.fill_count = r_fill;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_bmat_bank_buf.sv
// Directed bench: raw 8x8 buffer plus two small FFIP (row-difference) buffers.
module tb_bmat_bank_buf;
  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  bmat_bank_buf_if #(.SZI(8), .SZJ(8), .WIDTH(8), .NBANKS(2), .YGEN_MODE(0)) bus0 ();
  bmat_bank_buf_if #(.SZI(4), .SZJ(2), .WIDTH(8), .NBANKS(2), .YGEN_MODE(1)) bus1 ();
  bmat_bank_buf_if #(.SZI(2), .SZJ(2), .WIDTH(8), .NBANKS(2), .YGEN_MODE(1)) bus2 ();

  bmat_bank_buf #(.SZI(8), .SZJ(8), .WIDTH(8), .NBANKS(2), .YGEN_MODE(0), .SIGNED(1)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0.slave));
  bmat_bank_buf #(.SZI(4), .SZJ(2), .WIDTH(8), .NBANKS(2), .YGEN_MODE(1), .SIGNED(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave));
  bmat_bank_buf #(.SZI(2), .SZJ(2), .WIDTH(8), .NBANKS(2), .YGEN_MODE(1), .SIGNED(0)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 8x8 tile whose row i holds base+i in every column.
  function automatic logic [511:0] tile0(input logic [7:0] base);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[(j*8+i)*8 +: 8] = base + 8'(i);
      end
    end
    return r;
  endfunction

  // One beat on bus0, waiting (bounded) for d_ready; called at posedge+1.
  task automatic beat(input logic [7:0] val, input logic last);
    logic acc;
    acc          = 1'b0;
    bus0.d       = {8{val}};
    bus0.d_last  = last;
    bus0.d_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (bus0.d_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("beat_accept", {63'd0, acc}, 64'd1);
    bus0.d_valid = 1'b0;
    bus0.d_last  = 1'b0;
  endtask

  task automatic tile(input logic [7:0] base);
    for (int i = 0; i < 8; i++) beat(base + 8'(i), i == 7);
  endtask

  task automatic pulse_swap();
    bus0.swap = 1'b1;
    @(posedge clk);
    #1;
    bus0.swap = 1'b0;
  endtask

  logic [7:0]   r1 [4];
  logic [8:0]   y1 [4];
  logic [7:0]   r2 [2];
  logic [8:0]   y2 [2];
  logic [511:0] exp_q;

  initial begin
    resetn = 1'b0;
    bus0.d_valid = 0; bus0.d = '0; bus0.d_last = 0; bus0.swap = 0;
    bus1.d_valid = 0; bus1.d = '0; bus1.d_last = 0; bus1.swap = 0;
    bus2.d_valid = 0; bus2.d = '0; bus2.d_last = 0; bus2.swap = 0;
    r1[0] = 8'h05; r1[1] = 8'hFD; r1[2] = 8'h7F; r1[3] = 8'h80;
    y1[0] = 9'h005; y1[1] = 9'h1F8; y1[2] = 9'h082; y1[3] = 9'h101;
    r2[0] = 8'hFF; r2[1] = 8'h00;
    y2[0] = 9'h0FF; y2[1] = 9'h101;

    #12;
    chk("rst_q_valid", {63'd0, bus0.q_valid}, 64'd0);
    chk("rst_d_ready", {63'd0, bus0.d_ready}, 64'd0);
    chk("rst_fill", {62'd0, bus0.fill_count}, 64'd0);
    chk("rst_err", {63'd0, bus0.err}, 64'd0);
    chkw("rst_q", bus0.q, '0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_d_ready0", {63'd0, bus0.d_ready}, 64'd1);
    chk("rel_d_ready1", {63'd0, bus1.d_ready}, 64'd1);

    // Signed FFIP rows 5, -3, 127, -128.
    for (int i = 0; i < 4; i++) begin
      bus1.d = {2{r1[i]}}; bus1.d_last = (i == 3); bus1.d_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus1.d_valid = 1'b0; bus1.d_last = 1'b0;
    chk("ygen_s_not_yet", {63'd0, bus1.q_valid}, 64'd0);
    @(posedge clk);
    #1;
    exp_q = '0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++) exp_q[(j*4+i)*9 +: 9] = y1[i];
    chk("ygen_s_q_valid", {63'd0, bus1.q_valid}, 64'd1);
    chkw("ygen_s_q", {440'd0, bus1.q}, exp_q);
    chk("ygen_s_err", {63'd0, bus1.err}, 64'd0);

    // Unsigned FFIP rows 255, 0.
    for (int i = 0; i < 2; i++) begin
      bus2.d = {2{r2[i]}}; bus2.d_last = (i == 1); bus2.d_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus2.d_valid = 1'b0; bus2.d_last = 1'b0;
    @(posedge clk);
    #1;
    exp_q = '0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) exp_q[(j*2+i)*9 +: 9] = y2[i];
    chkw("ygen_u_q", {476'd0, bus2.q}, exp_q);

    // Tile A: first tile visible one cycle after it goes FULL.
    tile(8'h01);
    chk("a_q_valid_late", {63'd0, bus0.q_valid}, 64'd0);
    chk("a_fill_full", {62'd0, bus0.fill_count}, 64'd1);
    @(posedge clk);
    #1;
    chk("a_q_valid", {63'd0, bus0.q_valid}, 64'd1);
    chkw("a_q", bus0.q, tile0(8'h01));
    chk("a_fill", {62'd0, bus0.fill_count}, 64'd1);
    chk("a_err", {63'd0, bus0.err}, 64'd0);

    // Tile B fills the ring; tile C stalls.
    tile(8'h21);
    chk("b_d_ready", {63'd0, bus0.d_ready}, 64'd0);
    chk("b_fill", {62'd0, bus0.fill_count}, 64'd2);
    bus0.d = {8{8'h41}}; bus0.d_last = 1'b0; bus0.d_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("c_stall_ready", {63'd0, bus0.d_ready}, 64'd0);
    chk("c_stall_fill", {62'd0, bus0.fill_count}, 64'd2);
    chkw("c_stall_q", bus0.q, tile0(8'h01));
    pulse_swap();
    chk("swap_zb_valid", {63'd0, bus0.q_valid}, 64'd1);
    chkw("swap_zb_q", bus0.q, tile0(8'h21));
    chk("swap_zb_fill", {62'd0, bus0.fill_count}, 64'd1);
    chk("swap_zb_ready", {63'd0, bus0.d_ready}, 64'd1);
    tile(8'h41);
    chk("c_fill", {62'd0, bus0.fill_count}, 64'd2);
    chk("c_d_ready", {63'd0, bus0.d_ready}, 64'd0);
    chkw("c_q_still_b", bus0.q, tile0(8'h21));

    // Mid-tile reset with a tile ACTIVE.
    pulse_swap();
    chkw("c_q", bus0.q, tile0(8'h41));
    for (int i = 0; i < 4; i++) beat(8'h51 + 8'(i), 1'b0);
    chk("part_fill", {62'd0, bus0.fill_count}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chkw("mid_rst_q", bus0.q, '0);
    chk("mid_rst_q_valid", {63'd0, bus0.q_valid}, 64'd0);
    chk("mid_rst_fill", {62'd0, bus0.fill_count}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus0.d_ready}, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel2_d_ready", {63'd0, bus0.d_ready}, 64'd1);
    tile(8'h61);
    @(posedge clk);
    #1;
    chkw("e_q", bus0.q, tile0(8'h61));
    chk("e_fill", {62'd0, bus0.fill_count}, 64'd1);
    chk("e_err", {63'd0, bus0.err}, 64'd0);

    // Swap while nothing is presented.
    pulse_swap();
    chk("retire_q_valid", {63'd0, bus0.q_valid}, 64'd0);
    chk("retire_fill", {62'd0, bus0.fill_count}, 64'd0);
    chkw("retire_q", bus0.q, '0);
    chk("retire_err", {63'd0, bus0.err}, 64'd0);
    pulse_swap();
    chk("bad_swap_err", {63'd0, bus0.err}, 64'd1);
    chk("bad_swap_fill", {62'd0, bus0.fill_count}, 64'd0);
    chk("bad_swap_q_valid", {63'd0, bus0.q_valid}, 64'd0);

    // Early d_last: error, but the tile keeps its full length.
    resetn = 1'b0;
    #1;
    chk("rst3_err", {63'd0, bus0.err}, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) beat(8'h81 + 8'(i), 1'b0);
    chk("early_pre_err", {63'd0, bus0.err}, 64'd0);
    beat(8'h84, 1'b1);
    chk("early_err", {63'd0, bus0.err}, 64'd1);
    chk("early_no_close", {62'd0, bus0.fill_count}, 64'd0);
    for (int i = 4; i < 8; i++) beat(8'h81 + 8'(i), 1'b0);
    chk("late_close_fill", {62'd0, bus0.fill_count}, 64'd1);
    @(posedge clk);
    #1;
    chk("f_q_valid", {63'd0, bus0.q_valid}, 64'd1);
    chkw("f_q", bus0.q, tile0(8'h81));
    chk("f_err_sticky", {63'd0, bus0.err}, 64'd1);

    // Swap on the same edge as the next tile's close: one-cycle bubble.
    for (int i = 0; i < 7; i++) beat(8'hA1 + 8'(i), 1'b0);
    chk("g_ready", {63'd0, bus0.d_ready}, 64'd1);
    bus0.d = {8{8'hA8}}; bus0.d_last = 1'b1; bus0.d_valid = 1'b1; bus0.swap = 1'b1;
    @(posedge clk);
    #1;
    bus0.d_valid = 1'b0; bus0.d_last = 1'b0; bus0.swap = 1'b0;
    chk("bubble_q_valid", {63'd0, bus0.q_valid}, 64'd0);
    chkw("bubble_q", bus0.q, '0);
    chk("bubble_fill", {62'd0, bus0.fill_count}, 64'd1);
    @(posedge clk);
    #1;
    chk("g_q_valid", {63'd0, bus0.q_valid}, 64'd1);
    chkw("g_q", bus0.q, tile0(8'hA1));
    chk("g_d_ready", {63'd0, bus0.d_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
